// File: rtl/hc595_pkg.sv
// Shared types, constants and helpers for the 74HC595 link frame receiver.
package hc595_pkg;

    localparam int unsigned FRAME_W = 16;
    localparam int unsigned SEG_W   = 8;
    localparam int unsigned DIGITS  = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_W   = 5;

    typedef logic [SEG_W-1:0] seg_t;

    typedef struct packed {
        seg_t             seg;
        logic [DIGITS-1:0] sel;
    } frame_t;

    // Active-high 7-segment glyphs for hex digits 0..F (bit0=a .. bit6=g)
    localparam seg_t HEX_GLYPH [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    // Returns {exactly_one_bit_set, index_of_set_bit}
    function automatic logic [IDX_W:0] onehot_idx(input logic [DIGITS-1:0] sel);
        logic [IDX_W:0] r;
        int unsigned    n;
        r = '0;
        n = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel[i]) begin
                n = n + 1;
                r[IDX_W-1:0] = IDX_W'(i);
            end
        end
        r[IDX_W] = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/hc595_sync_edge.sv
// Two-flop synchroniser plus edge register for one asynchronous link wire.
module hc595_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise_c
);

    logic s1, s2, s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level  = s2;
    assign rise_c = s2 & ~s3;

endmodule

// File: rtl/hc595_frame_receiver.sv
// Deserialises {SEG,SEL} frames from a 74HC595 link and rebuilds the 8-digit image.
// Optional hex decode of the image is built when SEG_DECODE_EN is defined.
module hc595_frame_receiver
    import hc595_pkg::*;
#(
    parameter bit          SEL_ACTIVE_LOW = 1'b1,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      SH_CP,
    input  logic                      ST_CP,
    input  logic                      DS,
    output logic [FRAME_W-1:0]        Frame_Data,
    output logic                      Frame_Valid,
    output logic                      Frame_Err,
    output logic [ERR_CNT_W-1:0]      Err_Cnt,
    output logic [IDX_W-1:0]          Digit_Idx,
    output logic                      Digit_Update,
    output logic [DIGITS*SEG_W-1:0]   Digit_Seg,
    output logic [DIGITS*4-1:0]       Disp_Data,
    output logic [DIGITS-1:0]         Point_Mask,
    output logic                      Decode_Err
);

    logic sh_lvl, sh_rise, st_lvl, st_rise, ds_lvl, ds_rise;
    logic unused_sync;

    hc595_sync_edge u_sync_sh (.clk(Clk), .rst_n(Reset_n), .din(SH_CP), .level(sh_lvl), .rise_c(sh_rise));
    hc595_sync_edge u_sync_st (.clk(Clk), .rst_n(Reset_n), .din(ST_CP), .level(st_lvl), .rise_c(st_rise));
    hc595_sync_edge u_sync_ds (.clk(Clk), .rst_n(Reset_n), .din(DS),    .level(ds_lvl), .rise_c(ds_rise));

    assign unused_sync = &{1'b0, sh_lvl, st_lvl, ds_rise};

    logic [FRAME_W-1:0] shreg;
    logic [CNT_W-1:0]   bit_cnt;

    logic [FRAME_W-1:0] shifted_c, latch_val_c;
    logic [CNT_W-1:0]   cnt_inc_c, latch_cnt_c;
    frame_t             frame_c;
    logic [DIGITS-1:0]  sel_eff_c;
    logic [IDX_W:0]     oh_c;
    seg_t               seg_val_c;
    logic               good_c;

    // A coincident shift and latch latches the freshly shifted value and count
    always_comb begin
        shifted_c   = {shreg[FRAME_W-2:0], ds_lvl};
        cnt_inc_c   = (bit_cnt == '1) ? bit_cnt : bit_cnt + CNT_W'(1);
        latch_val_c = sh_rise ? shifted_c : shreg;
        latch_cnt_c = sh_rise ? cnt_inc_c : bit_cnt;
        frame_c     = frame_t'(latch_val_c);
        sel_eff_c   = SEL_ACTIVE_LOW ? ~frame_c.sel : frame_c.sel;
        oh_c        = onehot_idx(sel_eff_c);
        seg_val_c   = SEG_ACTIVE_LOW ? ~frame_c.seg : frame_c.seg;
        good_c      = (latch_cnt_c == CNT_W'(FRAME_W)) && oh_c[IDX_W];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            shreg        <= '0;
            bit_cnt      <= '0;
            Frame_Data   <= '0;
            Frame_Valid  <= 1'b0;
            Frame_Err    <= 1'b0;
            Err_Cnt      <= '0;
            Digit_Idx    <= '0;
            Digit_Update <= 1'b0;
            Digit_Seg    <= '0;
        end else begin
            Frame_Valid  <= 1'b0;
            Frame_Err    <= 1'b0;
            Digit_Update <= 1'b0;
            if (sh_rise) begin
                shreg   <= shifted_c;
                bit_cnt <= cnt_inc_c;
            end
            if (st_rise) begin
                Frame_Data  <= latch_val_c;
                bit_cnt     <= '0;
                Frame_Valid <= 1'b1;
                if (good_c) begin
                    Digit_Seg[{oh_c[IDX_W-1:0], 3'b000} +: SEG_W] <= seg_val_c;
                    Digit_Idx    <= oh_c[IDX_W-1:0];
                    Digit_Update <= 1'b1;
                end else begin
                    Frame_Err <= 1'b1;
                    if (Err_Cnt != '1) Err_Cnt <= Err_Cnt + ERR_CNT_W'(1);
                end
            end
        end
    end

`ifdef SEG_DECODE_EN
    logic [DIGITS*4-1:0] dec_data_c;
    logic [DIGITS-1:0]   dec_dp_c;
    logic                dec_err_c;
    seg_t                dig_c;
    logic                hit_c;

    // Match each digit's a..g pattern against the hex glyph table
    always_comb begin
        dec_data_c = '0;
        dec_dp_c   = '0;
        dec_err_c  = 1'b0;
        dig_c      = '0;
        hit_c      = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            dig_c       = Digit_Seg[k*SEG_W +: SEG_W];
            dec_dp_c[k] = dig_c[SEG_W-1];
            hit_c       = 1'b0;
            for (int g = 0; g < 16; g++) begin
                if (dig_c[6:0] == HEX_GLYPH[g][6:0]) begin
                    dec_data_c[k*4 +: 4] = 4'(g);
                    hit_c                = 1'b1;
                end
            end
            if (!hit_c) dec_err_c = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Disp_Data  <= '0;
            Point_Mask <= '0;
            Decode_Err <= 1'b0;
        end else if (Digit_Update) begin
            Disp_Data  <= dec_data_c;
            Point_Mask <= dec_dp_c;
            Decode_Err <= dec_err_c;
        end
    end
`else
    assign Disp_Data  = '0;
    assign Point_Mask = '0;
    assign Decode_Err = 1'b0;
`endif

endmodule

// File: tb/tb_hc595_frame_receiver.sv
// Self-checking bench for hc595_frame_receiver: directed and random link traffic vs. a frame-level model.
module tb_hc595_frame_receiver;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        SH_CP = 1'b0, ST_CP = 1'b0, DS = 1'b0;
    logic [15:0] Frame_Data;
    logic        Frame_Valid, Frame_Err, Digit_Update, Decode_Err;
    logic [7:0]  Err_Cnt, Point_Mask;
    logic [2:0]  Digit_Idx;
    logic [63:0] Digit_Seg;
    logic [31:0] Disp_Data;

    hc595_frame_receiver dut (
        .Clk(Clk), .Reset_n(Reset_n), .SH_CP(SH_CP), .ST_CP(ST_CP), .DS(DS),
        .Frame_Data(Frame_Data), .Frame_Valid(Frame_Valid), .Frame_Err(Frame_Err),
        .Err_Cnt(Err_Cnt), .Digit_Idx(Digit_Idx), .Digit_Update(Digit_Update),
        .Digit_Seg(Digit_Seg), .Disp_Data(Disp_Data), .Point_Mask(Point_Mask),
        .Decode_Err(Decode_Err)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Independent glyph table for the decode model
    logic [7:0] glyph [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    // Frame-level model: bit history, shifts since last latch, image and counters
    bit         hist[$];
    int         m_shifts = 0;
    logic [7:0] m_img [8];
    int         m_errs = 0;
    logic [2:0] m_idx = '0;
    logic [31:0] m_disp = '0;
    logic [7:0]  m_pm = '0;
    logic        m_derr = 1'b0;

    function automatic logic [63:0] img_packed();
        logic [63:0] r;
        for (int k = 0; k < 8; k++) r[k*8 +: 8] = m_img[k];
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_shifts = 0;
        for (int k = 0; k < 8; k++) m_img[k] = 8'h00;
        m_errs = 0; m_idx = '0; m_disp = '0; m_pm = '0; m_derr = 1'b0;
    endtask

    task automatic model_shift(input bit b);
        hist.push_back(b);
        if (hist.size() > 16) void'(hist.pop_front());
        m_shifts++;
    endtask

    task automatic model_decode();
        logic hit;
        m_disp = '0; m_pm = '0; m_derr = 1'b0;
        for (int k = 0; k < 8; k++) begin
            m_pm[k] = m_img[k][7];
            hit = 1'b0;
            for (int g = 0; g < 16; g++)
                if (m_img[k][6:0] == glyph[g][6:0]) begin
                    m_disp[k*4 +: 4] = 4'(g);
                    hit = 1'b1;
                end
            if (!hit) m_derr = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic shift_bit(input bit b);
        @(negedge Clk) DS = b;
        idle(3);
        SH_CP = 1'b1;
        model_shift(b);
        idle(4);
        SH_CP = 1'b0;
        idle(3);
    endtask

    // Shifts v[n-1:0], MSB first
    task automatic send_bits(input logic [31:0] v, input int n);
        logic [31:0] t;
        t = v;
        for (int i = n - 1; i >= 0; i--) shift_bit(t[i]);
    endtask

    // Raise ST_CP (optionally together with SH_CP) and check the latch result cycle by cycle
    task automatic latch(input bit with_shift, input bit b);
        logic [15:0] exp_frame;
        logic [7:0]  sel_ah;
        int          n;
        bit          good;
        if (with_shift) begin
            @(negedge Clk) DS = b;
            idle(3);
        end
        @(negedge Clk);
        ST_CP = 1'b1;
        if (with_shift) begin
            SH_CP = 1'b1;
            model_shift(b);
        end
        exp_frame = '0;
        for (int i = 0; i < 16; i++)
            if (i < hist.size()) exp_frame[i] = hist[hist.size() - 1 - i];
        n = (m_shifts > 31) ? 31 : m_shifts;
        m_shifts = 0;
        sel_ah = ~exp_frame[7:0];
        good = (n == 16) && ($countones(sel_ah) == 1);
        if (good) begin
            for (int k = 0; k < 8; k++) if (sel_ah[k]) m_idx = 3'(k);
            m_img[m_idx] = ~exp_frame[15:8];
`ifdef SEG_DECODE_EN
            model_decode();
`endif
        end else begin
            m_errs++;
        end
        @(posedge Clk) #1 check("valid_e1", 64'(Frame_Valid), 64'd0);
        @(posedge Clk) #1 check("valid_e2", 64'(Frame_Valid), 64'd0);
        @(posedge Clk) #1;
        check("valid_e3", 64'(Frame_Valid), 64'd1);
        check("frame_data", 64'(Frame_Data), 64'(exp_frame));
        check("frame_err", 64'(Frame_Err), 64'(!good));
        check("digit_update", 64'(Digit_Update), 64'(good));
        check("digit_idx", 64'(Digit_Idx), 64'(m_idx));
        check("digit_seg", Digit_Seg, img_packed());
        check("err_cnt", 64'(Err_Cnt), 64'((m_errs > 255) ? 255 : m_errs));
        @(posedge Clk) #1;
        check("valid_e4", 64'(Frame_Valid | Frame_Err | Digit_Update), 64'd0);
        check("disp_data", 64'(Disp_Data), 64'(m_disp));
        check("point_mask", 64'(Point_Mask), 64'(m_pm));
        check("decode_err", 64'(Decode_Err), 64'(m_derr));
        @(negedge Clk);
        ST_CP = 1'b0;
        SH_CP = 1'b0;
        idle(4);
    endtask

    task automatic send_frame(input logic [15:0] f);
        send_bits(32'(f), 16);
        latch(1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fd"}, 64'(Frame_Data), 64'd0);
        check({tag, "_flags"}, 64'({Frame_Valid, Frame_Err, Digit_Update, Decode_Err}), 64'd0);
        check({tag, "_ecnt"}, 64'({Err_Cnt, Digit_Idx, Point_Mask}), 64'd0);
        check({tag, "_seg"}, Digit_Seg, 64'd0);
        check({tag, "_disp"}, 64'(Disp_Data), 64'd0);
    endtask

    initial begin
        logic [7:0]  seg_ah;
        logic [15:0] f;
        logic [2:0]  k3;
        model_reset();
        idle(3);
        check_all_zero("reset");
        @(negedge Clk) Reset_n = 1'b1;
        idle(2);

        // Basic frame: digit 0 shows '0'
        send_frame(16'hC0FE);
        check("c0fe_data", 64'(Frame_Data), 64'h0000_0000_0000_C0FE);
        check("c0fe_seg0", 64'(Digit_Seg[7:0]), 64'h3F);

        // Short frame
        send_bits(32'h0000_4DFD, 15);
        latch(1'b0, 1'b0);

        // Two digits selected
        send_frame(16'hF9FC);

        // Digits 0..7 show 1..8, dp on digit 3
        for (int k = 0; k < 8; k++) begin
            seg_ah = glyph[k + 1] | ((k == 3) ? 8'h80 : 8'h00);
            k3 = 3'(k);
            f = {~seg_ah, ~(8'h01 << k3)};
            send_frame(f);
        end
`ifdef SEG_DECODE_EN
        check("disp_87654321", 64'(Disp_Data), 64'h8765_4321);
        check("pmask_08", 64'(Point_Mask), 64'h08);
        check("decerr_0", 64'(Decode_Err), 64'd0);
`endif

        // Coincident final shift and latch
        send_bits(32'h0000_3EEF >> 1, 15);
        latch(1'b1, 1'b1);

        // Random traffic: mostly good frames, some junk lengths / selects
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) != 0) begin
                seg_ah = glyph[$urandom_range(0, 15)] | ($urandom_range(0, 1) ? 8'h80 : 8'h00);
                k3 = 3'($urandom_range(0, 7));
                send_frame({~seg_ah, ~(8'h01 << k3)});
            end else begin
                send_bits($urandom, $urandom_range(0, 20));
                latch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
        end

        // Saturate the error counter with empty latches
        for (int i = 0; i < 300; i++) latch(1'b0, 1'b0);
        check("err_cnt_sat", 64'(Err_Cnt), 64'hFF);

        // Reset in the middle of a frame, then a clean frame
        send_bits(32'h0000_00A5, 8);
        @(negedge Clk) Reset_n = 1'b0;
        #1 check_all_zero("midreset");
        model_reset();
        idle(3);
        @(negedge Clk) Reset_n = 1'b1;
        idle(2);
        send_frame(16'h92F7);
        check("post_reset_data", 64'(Frame_Data), 64'h92F7);
        check("post_reset_errcnt", 64'(Err_Cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
